// File: rtl/bip_datapath.sv
// bip_datapath -- execution datapath of the BIP accumulator CPU.
//
// The datapath takes the decoded control word from the control unit every
// cycle. It holds these parts:
//   - the accumulator
//   - the add/sub ALU
//   - the operand and memory muxes
//   - the internal data RAM
//
// Optional feature: define BIP_FLAGS_EN to add the registered Zero/Neg/Ovf
// status outputs. These flags update on every accumulator load.
//
// Ports:
//   clk       in   rising-edge system clock
//   reset     in   asynchronous active-low reset (clears Acc and flags only)
//   SelA      in   [1:0] acc source: 00 RAM data, 01 sext(Operand), 10 ALU, 11 hold
//   SelB      in   ALU B source: 0 RAM data, 1 sext(Operand)
//   WrAcc     in   load accumulator from the SelA mux
//   Op        in   ALU op: 0 add, 1 subtract
//   WrRam     in   write the current Acc into RAM[Operand]
//   RdRam     in   drive RAM read data onto the internal bus (else zero)
//   Operand   in   [OPND_W-1:0] immediate / RAM address
//   Acc       out  [DATA_W-1:0] accumulator
//   RamRdata  out  [DATA_W-1:0] gated RAM read bus
//   Zero, Neg, Ovf  out  status flags (BIP_FLAGS_EN only)
//
// RAM_FILE names an optional init image. It is left to the integrating
// memory flow, because this datapath builds the RAM without any init process.
module bip_datapath #(
    parameter int    DATA_W   = 16,
    parameter int    OPND_W   = 11,
    parameter int    ADDR_W   = 11,
    parameter string RAM_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        SelA,
    input  logic              SelB,
    input  logic              WrAcc,
    input  logic              Op,
    input  logic              WrRam,
    input  logic              RdRam,
    input  logic [OPND_W-1:0] Operand,
    output logic [DATA_W-1:0] Acc,
    output logic [DATA_W-1:0] RamRdata
`ifdef BIP_FLAGS_EN
   ,output logic              Zero,
    output logic              Neg,
    output logic              Ovf
`endif
);

    typedef enum logic [1:0] {
        ACC_RAM  = 2'b00,
        ACC_IMM  = 2'b01,
        ACC_ALU  = 2'b10,
        ACC_HOLD = 2'b11
    } acc_sel_e;

    acc_sel_e          sel;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] acc_next;
    logic              acc_ld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] ram [2**ADDR_W];

    // Operand is sign-extended into the data width. A wider operand cannot
    // be represented, so it is rejected at elaboration.
    if (OPND_W > DATA_W) begin : g_bad_opnd
        $error("bip_datapath: OPND_W (%0d) exceeds DATA_W (%0d), RAM_FILE=%s",
               OPND_W, DATA_W, RAM_FILE);
    end else if (OPND_W == DATA_W) begin : g_sext_eq
        assign sext = Operand;
    end else begin : g_sext
        assign sext = {{(DATA_W-OPND_W){Operand[OPND_W-1]}}, Operand};
    end

    assign sel  = acc_sel_e'(SelA);
    assign addr = Operand[ADDR_W-1:0];

    // The read is gated, so an unselected bus contributes zero rather than
    // stale RAM contents.
    assign RamRdata = RdRam ? ram[addr] : '0;

    assign alu_b   = SelB ? sext : RamRdata;
    assign alu_res = Op ? (Acc - alu_b) : (Acc + alu_b);

    always_comb begin
        acc_next = Acc;
        acc_ld   = 1'b0;
        case (sel)
            ACC_RAM:  begin acc_next = RamRdata; acc_ld = WrAcc; end
            ACC_IMM:  begin acc_next = sext;     acc_ld = WrAcc; end
            ACC_ALU:  begin acc_next = alu_res;  acc_ld = WrAcc; end
            default:  begin acc_next = Acc;      acc_ld = 1'b0;  end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Acc <= '0;
        end else if (acc_ld) begin
            Acc <= acc_next;
        end
    end

    // The RAM is never cleared. A write is qualified by reset, so a store
    // issued while reset is held is dropped. The RAM captures the
    // pre-edge Acc, which gives store-then-load ordering when WrRam and
    // WrAcc are asserted together.
    always_ff @(posedge clk) begin
        if (reset && WrRam) begin
            ram[addr] <= Acc;
        end
    end

`ifdef BIP_FLAGS_EN
    logic ovf_next;

    // Signed overflow: both add operands share a sign that the result
    // lacks, or a subtract whose operands differ in sign flips the sign
    // of Acc.
    always_comb begin
        ovf_next = 1'b0;
        if (sel == ACC_ALU) begin
            if (Op)
                ovf_next = (Acc[DATA_W-1] != alu_b[DATA_W-1]) &&
                           (alu_res[DATA_W-1] != Acc[DATA_W-1]);
            else
                ovf_next = (Acc[DATA_W-1] == alu_b[DATA_W-1]) &&
                           (alu_res[DATA_W-1] != Acc[DATA_W-1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Zero <= 1'b0;
            Neg  <= 1'b0;
            Ovf  <= 1'b0;
        end else if (acc_ld) begin
            Zero <= (acc_next == '0);
            Neg  <= acc_next[DATA_W-1];
            Ovf  <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_bip_datapath.sv
module tb_bip_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  SelA;
    logic        SelB, WrAcc, Op, WrRam, RdRam;
    logic [10:0] Operand;
    logic [15:0] Acc, RamRdata;
`ifdef BIP_FLAGS_EN
    logic        Zero, Neg, Ovf;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bip_datapath #(.DATA_W(16), .OPND_W(11), .ADDR_W(11), .RAM_FILE("")) dut (
        .clk(clk), .reset(reset), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc),
        .Op(Op), .WrRam(WrRam), .RdRam(RdRam), .Operand(Operand),
        .Acc(Acc), .RamRdata(RamRdata)
`ifdef BIP_FLAGS_EN
       ,.Zero(Zero), .Neg(Neg), .Ovf(Ovf)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Drive one control word, then let one rising edge consume it.
    task automatic cw(input logic [1:0] sa, input logic sb, input logic wa, input logic op,
                      input logic wr, input logic rd, input logic [10:0] opd);
        SelA = sa; SelB = sb; WrAcc = wa; Op = op; WrRam = wr; RdRam = rd; Operand = opd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        SelA = 2'b00; SelB = 1'b0; WrAcc = 1'b0; Op = 1'b0;
        WrRam = 1'b0; RdRam = 1'b0; Operand = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #1;
        check("reset_acc", Acc, 16'h0000);
        check("reset_rdata_gated", RamRdata, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b1;

        // LDI sign extension
        cw(2'b01, 0, 1, 0, 0, 0, 11'h7FF);
        check("ldi_7ff", Acc, 16'hFFFF);
        cw(2'b01, 0, 1, 0, 0, 0, 11'h3FF);
        check("ldi_3ff", Acc, 16'h03FF);

        // Store then load
        cw(2'b01, 0, 1, 0, 0, 0, 11'h0AA);
        cw(2'b00, 0, 0, 0, 1, 0, 11'd5);
        check("store_acc_hold", Acc, 16'h00AA);
        idle(); RdRam = 1'b1; Operand = 11'd5; #1;
        check("ram5_read", RamRdata, 16'h00AA);
        cw(2'b01, 0, 1, 0, 0, 0, 11'h000);
        cw(2'b00, 0, 1, 0, 0, 1, 11'd5);
        check("load_ram5", Acc, 16'h00AA);

        // Wrap on add
        cw(2'b01, 0, 1, 0, 0, 0, 11'h7FF);
        cw(2'b10, 1, 1, 0, 0, 0, 11'd1);
        check("addi_wrap", Acc, 16'h0000);
`ifdef BIP_FLAGS_EN
        check("addi_wrap_zero", {15'd0, Zero}, 16'h0001);
`endif

        // Build 0x8000: 0xFC00 doubled five times through RAM[7]
        cw(2'b01, 0, 1, 0, 0, 0, 11'h400);
        check("ldi_400", Acc, 16'hFC00);
        for (int i = 0; i < 5; i++) begin
            cw(2'b00, 0, 0, 0, 1, 0, 11'd7);
            cw(2'b10, 0, 1, 0, 0, 1, 11'd7);
        end
        check("double_to_8000", Acc, 16'h8000);
        cw(2'b10, 1, 1, 1, 0, 0, 11'd1);
        check("subi_ovf", Acc, 16'h7FFF);
`ifdef BIP_FLAGS_EN
        check("subi_ovf_flag", {15'd0, Ovf}, 16'h0001);
`endif

        // Same-cycle store + load: the RAM receives the old Acc
        cw(2'b01, 0, 1, 0, 0, 0, 11'h011);
        cw(2'b01, 0, 1, 0, 1, 0, 11'h022);
        check("same_cycle_acc", Acc, 16'h0022);
        idle(); RdRam = 1'b1; Operand = 11'h022; #1;
        check("same_cycle_ram", RamRdata, 16'h0011);

        // Reserved select holds; a gated bus adds zero
        cw(2'b11, 0, 1, 0, 0, 1, 11'h022);
        check("sela_11_hold", Acc, 16'h0022);
        SelA = 2'b10; SelB = 1'b0; WrAcc = 1'b1; Op = 1'b0;
        WrRam = 1'b0; RdRam = 1'b0; Operand = 11'd5; #1;
        check("gated_rdata_zero", RamRdata, 16'h0000);
        @(posedge clk); #1;
        check("add_gated_zero", Acc, 16'h0022);

        // Asynchronous reset mid-run with a pending store to RAM[5]
        idle(); WrRam = 1'b1; Operand = 11'd5; #1;
        reset = 1'b0; #1;
        check("async_reset_acc", Acc, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(); RdRam = 1'b1; Operand = 11'd5; #1;
        check("ram5_kept_after_reset", RamRdata, 16'h00AA);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
